// File: rtl/axi_read_slave_if.sv
// rtl/axi_read_slave_if.sv - AXI read address and read data channel bundle.
interface axi_read_slave_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
);
  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [3:0]            ARLEN;
  logic [1:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ID_WIDTH-1:0]   RID;
  logic [BUS_WIDTH-1:0]  RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_read_slave.sv
// rtl/axi_read_slave.sv - AXI read slave: one burst at a time, FIXED/INCR/WRAP
// address generation, one synchronous memory read per R beat.
module axi_read_slave #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32,
  parameter int MEM_AW     = 7
) (
  input  logic                 clk,
  input  logic                 clr,
  axi_read_slave_if.slave      bus,
  output logic                 mem_rd,
  output logic [MEM_AW-1:0]    mem_raddr,
  input  logic [BUS_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [3:0]            len_q;
  logic [3:0]            beat_cnt;
  logic [1:0]            size_q;
  logic [1:0]            burst_q;

  logic                  wrap_ok;
  logic                  err;
  logic [ADDR_WIDTH-1:0] bsz;
  logic [ADDR_WIDTH-1:0] wsz;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Illegal WRAP lengths and the reserved burst type fall back to INCR addressing.
  always_comb begin
    wrap_ok = (len_q == 4'd1) || (len_q == 4'd3) || (len_q == 4'd7) || (len_q == 4'd15);
    err     = (burst_q == 2'b11) || ((burst_q == 2'b10) && !wrap_ok);
    bsz     = ADDR_WIDTH'(1) << size_q;
    wsz     = ADDR_WIDTH'({1'b0, len_q} + 5'd1) << size_q;
    if (burst_q == 2'b00)
      next_addr = cur_addr;
    else if ((burst_q == 2'b10) && wrap_ok)
      next_addr = (cur_addr & ~(wsz - 1'b1)) | ((cur_addr + bsz) & (wsz - 1'b1));
    else
      next_addr = (cur_addr & ~(bsz - 1'b1)) + bsz;
  end

  assign bus.ARREADY = (state == IDLE) && !clr;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      bus.RVALID <= 1'b0;
      bus.RLAST  <= 1'b0;
      bus.RID    <= '0;
      bus.RDATA  <= '0;
      bus.RRESP  <= 2'b00;
      mem_rd     <= 1'b0;
      mem_raddr  <= '0;
      id_q       <= '0;
      cur_addr   <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      size_q     <= '0;
      burst_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ARVALID) begin
            id_q      <= bus.ARID;
            cur_addr  <= bus.ARADDR;
            len_q     <= bus.ARLEN;
            size_q    <= bus.ARSIZE;
            burst_q   <= bus.ARBURST;
            beat_cnt  <= 4'd0;
            mem_rd    <= 1'b1;
            mem_raddr <= bus.ARADDR[MEM_AW-1:0];
            state     <= RD;
          end
        end
        RD: begin
          mem_rd <= 1'b0;
          state  <= CAP;
        end
        CAP: begin
          bus.RDATA  <= mem_rdata;
          bus.RID    <= id_q;
          bus.RRESP  <= err ? 2'b10 : 2'b00;
          bus.RLAST  <= (beat_cnt == len_q);
          bus.RVALID <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (bus.RREADY) begin
            bus.RVALID <= 1'b0;
            if (bus.RLAST) begin
              state <= IDLE;
            end else begin
              beat_cnt  <= beat_cnt + 4'd1;
              cur_addr  <= next_addr;
              mem_rd    <= 1'b1;
              mem_raddr <= next_addr[MEM_AW-1:0];
              state     <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
